// File: rtl/cr_clic_scan_arb.sv
`default_nettype none
// ============================================================================
// Module   : cr_clic_scan_arb
// Purpose  : Multi-cycle sequential CLIC arbiter. Each clicreg_clk cycle one
//            group of GRP interrupt sources is compared against a running
//            best candidate. After the last group, the winner's mode, level,
//            id and hv are committed to the arb_ctrl_int_* registers that
//            cr_clic_ctrl consumes. This trades a few cycles of latency for
//            a much smaller comparator than a flat INTNUM-wide tree.
// Ports    :
//   clicreg_clk        clock
//   cpurst_b           asynchronous active-low reset
//   kid_arb_ip/ie      per-source pending / enable
//   kid_arb_ctl        per-source clicintctl, source i at [8i+7:8i]
//   kid_arb_mode       per-source mode (1 = M, 0 = U)
//   kid_arb_hv         per-source selective-hardware-vectoring bit
//   ctrl_lv_or_mask    level OR-mask derived from cliccfg.nlbits
//   arb_restart        abort the running sweep and restart from group 0
//   arb_ctrl_int_*     committed winner (hv, id, il, mode, vld)
//   arb_sweep_done     one-cycle pulse while the FSM is in COMMIT
// Revision : 1.0 - initial release
// ============================================================================
module cr_clic_scan_arb #(
    parameter int INTNUM   = 80,
    parameter int GRP      = 8,
    parameter int ID_WIDTH = 12
) (
    input  logic                  clicreg_clk,
    input  logic                  cpurst_b,
    input  logic [INTNUM-1:0]     kid_arb_ip,
    input  logic [INTNUM-1:0]     kid_arb_ie,
    input  logic [INTNUM*8-1:0]   kid_arb_ctl,
    input  logic [INTNUM-1:0]     kid_arb_mode,
    input  logic [INTNUM-1:0]     kid_arb_hv,
    input  logic [7:0]            ctrl_lv_or_mask,
    input  logic                  arb_restart,
    output logic                  arb_ctrl_int_hv,
    output logic [ID_WIDTH-1:0]   arb_ctrl_int_id,
    output logic [7:0]            arb_ctrl_int_il,
    output logic                  arb_ctrl_int_mode,
    output logic                  arb_ctrl_int_vld,
    output logic                  arb_sweep_done
);

    localparam int NGRP  = (INTNUM + GRP - 1) / GRP;
    localparam int NSLOT = NGRP * GRP;
    localparam int GW    = (NGRP  > 1) ? $clog2(NGRP)  : 1;
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Source vectors padded to a whole number of groups. Padding slots in
    // the last partial group are tied off so they can never win.
    // ------------------------------------------------------------------
    logic [NSLOT-1:0] cand_pad;
    logic [NSLOT-1:0] mode_pad;
    logic [NSLOT-1:0] hv_pad;
    logic [7:0]       il_pad [NSLOT];

    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        if (s < INTNUM) begin : g_src
            assign cand_pad[s] = kid_arb_ip[s] & kid_arb_ie[s];
            assign mode_pad[s] = kid_arb_mode[s];
            assign hv_pad[s]   = kid_arb_hv[s];
            assign il_pad[s]   = kid_arb_ctl[s*8 +: 8] | ctrl_lv_or_mask;
        end else begin : g_pad
            assign cand_pad[s] = 1'b0;
            assign mode_pad[s] = 1'b0;
            assign hv_pad[s]   = 1'b0;
            assign il_pad[s]   = 8'h00;
        end
    end

    logic any_cand;
    assign any_cand = |cand_pad;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [GW-1:0]       grp_idx_q,   grp_idx_d;

    logic                best_vld_q,  best_vld_d;
    logic                best_mode_q, best_mode_d;
    logic [7:0]          best_il_q,   best_il_d;
    logic [ID_WIDTH-1:0] best_id_q,   best_id_d;
    logic                best_hv_q,   best_hv_d;

    logic                out_vld_q,   out_vld_d;
    logic                out_mode_q,  out_mode_d;
    logic [7:0]          out_il_q,    out_il_d;
    logic [ID_WIDTH-1:0] out_id_q,    out_id_d;
    logic                out_hv_q,    out_hv_d;

    // ------------------------------------------------------------------
    // Winner of the group currently addressed by grp_idx_q. Lanes are
    // visited in ascending id order and only a strictly better {mode,il}
    // replaces the holder, so ties resolve to the lowest id.
    // ------------------------------------------------------------------
    logic                grp_vld;
    logic                grp_mode;
    logic [7:0]          grp_il;
    logic [ID_WIDTH-1:0] grp_id;
    logic                grp_hv;
    logic [SW-1:0]       slot;

    always_comb begin
        grp_vld  = 1'b0;
        grp_mode = 1'b0;
        grp_il   = 8'h00;
        grp_id   = '0;
        grp_hv   = 1'b0;
        slot     = '0;
        for (int lane = 0; lane < GRP; lane++) begin
            slot = SW'(int'(grp_idx_q) * GRP + lane);
            if (cand_pad[slot] &&
                (!grp_vld || ({mode_pad[slot], il_pad[slot]} > {grp_mode, grp_il}))) begin
                grp_vld  = 1'b1;
                grp_mode = mode_pad[slot];
                grp_il   = il_pad[slot];
                grp_id   = ID_WIDTH'(slot);
                grp_hv   = hv_pad[slot];
            end
        end
    end

    // Earlier groups hold lower ids, so the running best is kept on a tie.
    logic take_grp;
    assign take_grp = grp_vld &&
                      (!best_vld_q || ({grp_mode, grp_il} > {best_mode_q, best_il_q}));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grp_idx_d   = grp_idx_q;
        best_vld_d  = best_vld_q;
        best_mode_d = best_mode_q;
        best_il_d   = best_il_q;
        best_id_d   = best_id_q;
        best_hv_d   = best_hv_q;
        out_vld_d   = out_vld_q;
        out_mode_d  = out_mode_q;
        out_il_d    = out_il_q;
        out_id_d    = out_id_q;
        out_hv_d    = out_hv_q;

        case (state_q)
            ST_IDLE: begin
                if (any_cand || arb_restart) begin
                    state_d     = ST_SCAN;
                    grp_idx_d   = '0;
                    best_vld_d  = 1'b0;
                    best_mode_d = 1'b0;
                    best_il_d   = 8'h00;
                    best_id_d   = '0;
                    best_hv_d   = 1'b0;
                end
            end

            ST_SCAN: begin
                if (arb_restart) begin
                    // Discard partial result; committed outputs are left alone.
                    grp_idx_d   = '0;
                    best_vld_d  = 1'b0;
                    best_mode_d = 1'b0;
                    best_il_d   = 8'h00;
                    best_id_d   = '0;
                    best_hv_d   = 1'b0;
                end else begin
                    if (take_grp) begin
                        best_vld_d  = 1'b1;
                        best_mode_d = grp_mode;
                        best_il_d   = grp_il;
                        best_id_d   = grp_id;
                        best_hv_d   = grp_hv;
                    end
                    if (grp_idx_q == LAST_GRP) begin
                        state_d   = ST_COMMIT;
                        grp_idx_d = '0;
                    end else begin
                        grp_idx_d = grp_idx_q + GW'(1);
                    end
                end
            end

            ST_COMMIT: begin
                // best_* are all-zero when nothing was found, so an empty
                // sweep naturally drives a zero winner with vld low.
                out_vld_d   = best_vld_q;
                out_mode_d  = best_vld_q & best_mode_q;
                out_il_d    = best_vld_q ? best_il_q : 8'h00;
                out_id_d    = best_vld_q ? best_id_q : '0;
                out_hv_d    = best_vld_q & best_hv_q;
                state_d     = (any_cand || arb_restart) ? ST_SCAN : ST_IDLE;
                grp_idx_d   = '0;
                best_vld_d  = 1'b0;
                best_mode_d = 1'b0;
                best_il_d   = 8'h00;
                best_id_d   = '0;
                best_hv_d   = 1'b0;
            end

            default: begin
                state_d   = ST_IDLE;
                grp_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clicreg_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_IDLE;
            grp_idx_q   <= '0;
            best_vld_q  <= 1'b0;
            best_mode_q <= 1'b0;
            best_il_q   <= 8'h00;
            best_id_q   <= '0;
            best_hv_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_mode_q  <= 1'b0;
            out_il_q    <= 8'h00;
            out_id_q    <= '0;
            out_hv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_idx_q   <= grp_idx_d;
            best_vld_q  <= best_vld_d;
            best_mode_q <= best_mode_d;
            best_il_q   <= best_il_d;
            best_id_q   <= best_id_d;
            best_hv_q   <= best_hv_d;
            out_vld_q   <= out_vld_d;
            out_mode_q  <= out_mode_d;
            out_il_q    <= out_il_d;
            out_id_q    <= out_id_d;
            out_hv_q    <= out_hv_d;
        end
    end

    assign arb_ctrl_int_vld  = out_vld_q;
    assign arb_ctrl_int_mode = out_mode_q;
    assign arb_ctrl_int_il   = out_il_q;
    assign arb_ctrl_int_id   = out_id_q;
    assign arb_ctrl_int_hv   = out_hv_q;
    // Decoded from the state register, so the pulse is glitch-free.
    assign arb_sweep_done    = (state_q == ST_COMMIT);

endmodule
`default_nettype wire
